// File: rtl/shift_reg_serial_tx_if.sv
// Word-in / serial-out bundle of the PLL control shift-register loader.
// The master pushes parallel words. The slave (the transmitter) drives
// the serial side and the status outputs.
interface shift_reg_serial_tx_if #(
   parameter int WIDTH = 9
);
   logic [WIDTH-1:0] s_data;
   logic             s_valid;
   logic             s_ready;
   logic             en;
   logic             sdata;
   logic             busy;
   logic             frame_done;

   modport master (
      output s_data, s_valid,
      input  s_ready, en, sdata, busy, frame_done
   );

   modport slave (
      input  s_data, s_valid,
      output s_ready, en, sdata, busy, frame_done
   );
endinterface

// File: rtl/shift_reg_serial_tx.sv
// Parallel-to-serial transmitter feeding the PLL control shift register.
// It shifts each word out with an enable window, one bit per sclk.
// A one-word holding buffer allows back-to-back frames, and GAP idle
// cycles separate consecutive frames.
module shift_reg_serial_tx #(
   parameter int WIDTH     = 9,
   parameter int GAP       = 2,
   parameter int MSB_FIRST = 1
) (
   input  logic                 sclk,
   input  logic                 rst,
   shift_reg_serial_tx_if.slave bus
);
   localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_sr, w_sr_nxt;
   logic [WIDTH-1:0] r_hb, w_hb_nxt;
   logic             r_hb_full, w_hb_full_nxt;
   logic [BCW-1:0]   r_bc, w_bc_nxt;
   logic [GCW-1:0]   r_gc, w_gc_nxt;
   logic             r_frame_done, w_frame_done_nxt;
   logic             r_busy;
   logic             w_accept;
   logic             w_launch;
   logic             w_out_bit;
   logic [WIDTH-1:0] w_sr_shifted;

   // Output end of the shifter and the zero-filled shift toward it.
   if (MSB_FIRST != 0) begin : g_msb
      assign w_out_bit    = r_sr[WIDTH-1];
      assign w_sr_shifted = {r_sr[WIDTH-2:0], 1'b0};
   end else begin : g_lsb
      assign w_out_bit    = r_sr[0];
      assign w_sr_shifted = {1'b0, r_sr[WIDTH-1:1]};
   end

   // Ready depends only on the buffer flag, so s_valid has no
   // combinational path to it.
   assign w_accept       = bus.s_valid & ~r_hb_full;
   assign bus.s_ready    = ~r_hb_full;
   assign bus.en         = (r_state == S_SHIFT);
   assign bus.sdata      = (r_state == S_SHIFT) ? w_out_bit : 1'b0;
   assign bus.busy       = r_busy;
   assign bus.frame_done = r_frame_done;

   // Next-state logic. w_launch marks every point where a new frame may
   // start: the buffered word wins over a bypass of the incoming word.
   always_comb begin
      w_state_nxt      = r_state;
      w_sr_nxt         = r_sr;
      w_hb_nxt         = r_hb;
      w_hb_full_nxt    = r_hb_full;
      w_bc_nxt         = r_bc;
      w_gc_nxt         = r_gc;
      w_frame_done_nxt = 1'b0;
      w_launch         = 1'b0;

      case (r_state)
         S_IDLE: w_launch = 1'b1;
         S_SHIFT: begin
            w_sr_nxt = w_sr_shifted;
            w_bc_nxt = r_bc + BCW'(1);
            if (r_bc == BCW'(WIDTH - 1)) begin
               w_bc_nxt         = '0;
               w_frame_done_nxt = 1'b1;
               if (GAP > 0) begin
                  w_state_nxt = S_GAP;
                  w_gc_nxt    = GCW'(GAP - 1);
               end else begin
                  w_launch = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (r_gc == '0) w_launch = 1'b1;
            else            w_gc_nxt = r_gc - GCW'(1);
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_launch) begin
         if (r_hb_full) begin
            w_sr_nxt      = r_hb;
            w_hb_full_nxt = 1'b0;
            w_state_nxt   = S_SHIFT;
         end else if (w_accept) begin
            w_sr_nxt    = bus.s_data;
            w_state_nxt = S_SHIFT;
         end else begin
            w_state_nxt = S_IDLE;
         end
      end else if (w_accept) begin
         w_hb_nxt      = bus.s_data;
         w_hb_full_nxt = 1'b1;
      end
   end

   // State and datapath registers. Reset aborts any frame in flight.
   always_ff @(posedge sclk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_sr         <= '0;
         r_hb         <= '0;
         r_hb_full    <= 1'b0;
         r_bc         <= '0;
         r_gc         <= '0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sr         <= w_sr_nxt;
         r_hb         <= w_hb_nxt;
         r_hb_full    <= w_hb_full_nxt;
         r_bc         <= w_bc_nxt;
         r_gc         <= w_gc_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_busy       <= (w_state_nxt != S_IDLE) | w_hb_full_nxt;
      end
   end
endmodule

// File: tb/tb_shift_reg_serial_tx.sv
// Bench for shift_reg_serial_tx using a scoreboard with a timing model.
// Each accepted word is queued with its predicted first-bit cycle:
// start = max(accept cycle, previous frame end + GAP + 1). A negedge
// monitor acts as the receiver. It checks frame contents, frame start,
// frame_done timing, and the ready and busy levels derived from the
// queue.
module tb_shift_reg_serial_tx;
   localparam int WIDTH = 9;
   localparam int GAP   = 2;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               acc;
      int               start;
   } exp_t;

   logic sclk = 1'b0;
   logic rst  = 1'b1;
   shift_reg_serial_tx_if #(.WIDTH(WIDTH)) ifc ();

   shift_reg_serial_tx #(.WIDTH(WIDTH), .GAP(GAP), .MSB_FIRST(1)) dut (
      .sclk (sclk),
      .rst  (rst),
      .bus  (ifc.slave)
   );

   always #5 sclk = ~sclk;

   int               checks   = 0;
   int               errors   = 0;
   int               cyc      = 0;
   int               acc_cnt  = 0;
   int               last_end = -1000;
   int               rd       = 0;
   int               bitcnt   = 0;
   bit               chk_on   = 1'b0;
   logic [WIDTH-1:0] rx_q     = '0;
   exp_t             exp_q[$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard push: record each accepted word and predict its start.
   always @(posedge sclk) begin
      exp_t e;
      cyc++;
      if (!rst && ifc.s_valid && ifc.s_ready) begin
         e.data    = ifc.s_data;
         e.acc     = cyc;
         e.start   = (cyc > last_end + GAP + 1) ? cyc : last_end + GAP + 1;
         last_end  = e.start + WIDTH - 1;
         exp_q.push_back(e);
         acc_cnt++;
      end
   end

   // Monitor: reference receiver plus level checks, once per cycle.
   always @(negedge sclk) begin
      bit exp_rdy, exp_busy;
      if (chk_on) begin
         exp_rdy  = 1'b1;
         exp_busy = 1'b0;
         foreach (exp_q[i]) begin
            if (exp_q[i].acc <= cyc && cyc < exp_q[i].start) begin
               exp_rdy  = 1'b0;
               exp_busy = 1'b1;
            end
            if (exp_q[i].start <= cyc && cyc <= exp_q[i].start + WIDTH - 1 + GAP)
               exp_busy = 1'b1;
         end
         chk("s_ready", int'(ifc.s_ready), int'(exp_rdy));
         chk("busy", int'(ifc.busy), int'(exp_busy));
         if (ifc.frame_done) begin
            if (rd >= exp_q.size()) chk("spurious_frame_done", 1, 0);
            else begin
               chk("frame_bits", bitcnt, WIDTH);
               chk("frame_done_cycle", cyc, exp_q[rd].start + WIDTH);
               chk("rx_word", int'(rx_q), int'(exp_q[rd].data));
               rd++;
               bitcnt = 0;
            end
         end
         if (ifc.en) begin
            if (rd >= exp_q.size()) chk("spurious_en", 1, 0);
            else begin
               if (bitcnt == 0) chk("frame_start", cyc, exp_q[rd].start);
               rx_q   = {rx_q[WIDTH-2:0], ifc.sdata};
               bitcnt++;
            end
         end else begin
            chk("sdata_idle", int'(ifc.sdata), 0);
         end
      end
   end

   // One reset edge. The caller sits at a negedge. s_valid may be held
   // high to show that reset wins over acceptance.
   task automatic do_reset(input bit valid_during);
      rst         = 1'b1;
      chk_on      = 1'b0;
      ifc.s_valid = valid_during;
      ifc.s_data  = WIDTH'(9'h07E);
      @(negedge sclk);
      chk("rst_en", int'(ifc.en), 0);
      chk("rst_sdata", int'(ifc.sdata), 0);
      chk("rst_busy", int'(ifc.busy), 0);
      chk("rst_s_ready", int'(ifc.s_ready), 1);
      chk("rst_frame_done", int'(ifc.frame_done), 0);
      exp_q.delete();
      rd          = 0;
      bitcnt      = 0;
      last_end    = -1000;
      rst         = 1'b0;
      ifc.s_valid = 1'b0;
      chk_on      = 1'b1;
   endtask

   // Present a word and hold it until accepted. s_valid is left high.
   task automatic send(input logic [WIDTH-1:0] w);
      int n0 = acc_cnt;
      ifc.s_valid = 1'b1;
      ifc.s_data  = w;
      for (int t = 0; t < 100 && acc_cnt == n0; t++) @(negedge sclk);
      if (acc_cnt == n0) chk("accept_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      ifc.s_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         ifc.s_data = WIDTH'($urandom);
         @(negedge sclk);
      end
   endtask

   // Wait until every queued word has completed its frame.
   task automatic drain();
      int t = 0;
      ifc.s_valid = 1'b0;
      while (rd < exp_q.size() && t < 400) begin
         @(negedge sclk);
         t++;
      end
      if (rd < exp_q.size()) chk("drain_timeout", rd, exp_q.size());
      idle(4);
   endtask

   initial begin
      ifc.s_valid = 1'b0;
      ifc.s_data  = '0;
      do_reset(1'b0);
      idle(20);                        // idle hygiene
      send(9'h1A5); drain();           // single word
      send(9'h155); send(9'h0AA); drain();
      send(9'h001); send(9'h100); send(9'h0F0); drain();
      send(9'h1FF); send(9'h000); drain();
      // reset in the middle of a frame, then a clean frame
      send(9'h1A5);
      ifc.s_valid = 1'b0;
      for (int t = 0; t < 50 && bitcnt != 4; t++) @(negedge sclk);
      chk("reached_bit4", bitcnt, 4);
      do_reset(1'b0);
      idle(3);
      send(9'h003); drain();
      // reset coinciding with a valid word: nothing must be transmitted
      do_reset(1'b1);
      idle(25);
      // randomized traffic with random idle spacing
      for (int k = 0; k < 40; k++) begin
         int unsigned idl = $urandom_range(0, 14);
         if (idl > 8) idl = 0;
         if (idl != 0) idle(int'(idl));
         send(WIDTH'($urandom));
      end
      drain();
      chk("words_done", rd, exp_q.size());
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
